// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream bundle between N requesters, the arbiter and one uart_tx.
// Latency: none; this is wiring only.
// Backpressure: req_ready per requester, tx_ready from the transmitter.
//
// Ports: req_valid/req_data/req_last/req_ready are the requester side.
//        tx_data/tx_valid/tx_ready are the uart_tx side.
// master is the environment side (requesters plus uart_tx).
// slave is the arbiter side.
interface uart_tx_arbiter_if #(
    parameter int N = 4,
    parameter int W = 8
);
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   tx_data;
    logic           tx_valid;
    logic           tx_ready;

    modport master (
        output req_valid, req_data, req_last, tx_ready,
        input  req_ready, tx_data, tx_valid
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_ready,
        output req_ready, tx_data, tx_valid
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one uart_tx among N byte streams; a grant is held for a whole message.
// Latency: grant and tx_valid one cycle after req_valid in IDLE; data/ready combinational while LOCKED.
// Backpressure: tx_ready feeds only the owner's req_ready; transmitter stalls never count toward timeout.
//
// Ports: clk, rst (async, active-low); bus (slave modport: req_* in, req_ready out,
//        tx_data/tx_valid out, tx_ready in); grant (one-hot owner, zero when idle);
//        busy (high while LOCKED); timeout_evt (one-cycle pulse on forced release).
module uart_tx_arbiter #(
    parameter int N       = 4,
    parameter int W       = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_arbiter_if.slave bus,
    output logic [N-1:0]     grant,
    output logic             busy,
    output logic             timeout_evt
);
    localparam int PW   = (N > 1) ? $clog2(N) : 1;
    localparam int CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TLIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t        state_q, state_nxt;
    logic [N-1:0]  grant_q, grant_nxt;
    logic [PW-1:0] ptr_q, ptr_nxt;
    logic [CW-1:0] cnt_q, cnt_nxt;

    logic          owner_vld;
    logic          owner_last;
    logic [W-1:0]  owner_dat;
    logic [PW-1:0] owner_idx;

    logic [N-1:0]  ptr_mask;
    logic [N-1:0]  req_hi;
    logic [N-1:0]  pick;

    logic          locked;
    logic          xfer;
    logic          last_xfer;
    logic          expire;
    logic          rel;

    // Owner's view of the request bundle, selected by the registered one-hot grant.
    always_comb begin
        owner_vld  = 1'b0;
        owner_last = 1'b0;
        owner_dat  = '0;
        owner_idx  = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_q[i]) begin
                owner_vld  = bus.req_valid[i];
                owner_last = bus.req_last[i];
                owner_dat  = bus.req_data[i*W +: W];
                owner_idx  = PW'(i);
            end
        end
    end

    // Round-robin pick: lowest requester at or above ptr, else wrap to the lowest overall.
    // x & (~x + 1) isolates the lowest set bit.
    always_comb begin
        ptr_mask = ~((ONE << ptr_q) - ONE);
        req_hi   = bus.req_valid & ptr_mask;
        if (|req_hi) begin
            pick = req_hi & (~req_hi + ONE);
        end else begin
            pick = bus.req_valid & (~bus.req_valid + ONE);
        end
    end

    assign locked    = (state_q == LOCKED);
    assign xfer      = locked && owner_vld && bus.tx_ready;
    assign last_xfer = xfer && owner_last;
    // Expiry needs the owner silent, so it cannot coincide with a real transfer;
    // last_xfer still takes priority in rel and timeout_evt for clarity.
    assign expire    = (TIMEOUT > 0) && locked && !owner_vld && (cnt_q == CW'(TLIM));
    assign rel       = last_xfer || expire;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Grant, pointer and silence counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            grant_q <= grant_nxt;
            ptr_q   <= ptr_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state_q;
        grant_nxt = grant_q;
        ptr_nxt   = ptr_q;
        cnt_nxt   = cnt_q;
        case (state_q)
            IDLE: begin
                if (|bus.req_valid) begin
                    state_nxt = LOCKED;
                    grant_nxt = pick;
                    cnt_nxt   = '0;
                end
            end
            LOCKED: begin
                if (rel) begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                    cnt_nxt   = '0;
                    ptr_nxt   = (owner_idx == PW'(N - 1)) ? '0 : owner_idx + PW'(1);
                end else if (owner_vld) begin
                    cnt_nxt = '0;
                end else if (TIMEOUT > 0) begin
                    // Saturates at TLIM through the expiry release, so no wrap.
                    cnt_nxt = cnt_q + CW'(1);
                end
            end
        endcase
    end

    // Outputs: everything is gated by LOCKED so reset clears them without a clock.
    always_comb begin
        grant         = '0;
        busy          = 1'b0;
        bus.tx_valid  = 1'b0;
        bus.tx_data   = '0;
        bus.req_ready = '0;
        timeout_evt   = 1'b0;
        if (locked) begin
            grant         = grant_q;
            busy          = 1'b1;
            bus.tx_valid  = owner_vld;
            bus.tx_data   = owner_dat;
            bus.req_ready = grant_q & {N{bus.tx_ready}};
            timeout_evt   = expire && !last_xfer;
        end
    end
endmodule
